snake_dir_queue: RTL
====================

# snake_dir_queue

Direction front end for the snake game. It sits between the five button debouncers and `snake_core`, and runs on `board_clk`. It converts single-cycle debounced button pulses into a small FIFO of legal turns, then presents one turn per game step as a stable heading. This keeps the core from missing taps between steps, and from accepting a 180° reversal or a duplicate heading.

## Interface
Parameters:
- `DEPTH`, default 2: turn-queue entries, minimum 1.
- `CW`, default 2: queue count width; must satisfy 2^CW > DEPTH.

Ports (name, direction, width, meaning):
- `board_clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clock `board_clk`.
- `btn_u`, `btn_r`, `btn_d`, `btn_l` in 1 each: debounced single-cycle pulses (SCEN).
- `step` in 1: one-cycle pulse per game tick, synchronous to `board_clk`.
- `run` in 1: high while the game is in its playing state.
- `clear` in 1: synchronous restart. Heading returns to RIGHT and the queue empties.
- `dir` out 2: current heading. UP=0, RIGHT=1, DOWN=2, LEFT=3.
- `dir_chg` out 1: one-cycle pulse when `dir` changed on this edge.
- `count` out CW: number of queued turns.
- `drop` out 1: one-cycle pulse when a legal turn was discarded because the queue was full.

## Operation
- Reset or `clear` sets the following. `clear` has priority over everything else:
  - `dir` = RIGHT.
  - `count` = 0.
  - `dir_chg`, `drop` = 0.
  - Queue pointers = 0.
- Candidate selection: exactly one `btn_*` high gives the candidate. Zero or more than one high gives no candidate; the multi-press case is ignored entirely.
- Reference heading: the tail entry if `count` > 0, otherwise `dir`.
- Legality: a candidate is rejected if it equals the reference, or if candidate XOR reference == 2'b10 (opposite heading).
- Push: a legal candidate is written at the tail when `run` = 1.
  - If `count` == DEPTH and no pop happens this cycle, the candidate is discarded and `drop` pulses.
- Pop: when `step` = 1, `run` = 1 and `count` > 0, the head entry moves to `dir` and `dir_chg` pulses.
  - With an empty queue, `step` leaves `dir` unchanged and there is no pulse.
- Simultaneous push and pop:
  - Both happen in the same cycle and `count` is unchanged.
  - A full queue accepts the push.
  - The reference heading is the pre-pop tail. With `count` = 1, that entry becomes `dir`, so the legality result is the same either way.
- `run` = 0: buttons and `step` are ignored and the queue contents are held. Buttons are not buffered while paused.
- Pointers are modulo DEPTH. Wrap-around must not corrupt entries.

## Timing
- All state updates on the `posedge board_clk`. The only asynchronous path is `reset`.
- Button pulse on edge k: entry visible in `count` after edge k.
- `step` sampled on edge k: `dir` and `dir_chg` updated after edge k. Latency from button to heading is at least one `step`.
- `dir` is held stable between pops and is safe to sample from the slower game clock domain.
- `dir_chg` and `drop` are registered pulses, exactly one cycle wide.
- Reset asserted mid-operation clears the queue immediately. Any pending `step` or button pulse in that cycle is lost.

## Structure
- Shared package `snake_pkg` holds:
  - Direction encoding constants `DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`.
  - The reset heading `DIR_INIT` = `DIR_RIGHT`.
  - An `is_reverse(a,b)` function, reused by `snake_core`.
- One sub-module, `dir_fifo`: a DEPTH-entry, 2-bit circular FIFO. It has push/pop/clear inputs and exposes head, tail, count, full and empty.
- The top level holds candidate decode, legality, run gating and the `dir` register.

## Test plan
- Reset, then idle: `dir` = 1, `count` = 0. Then `btn_d` pulse and `step` with `run` = 1: `dir` = 2 and one `dir_chg` pulse.
- Heading RIGHT, `btn_l` pulse, then `step`: `count` stays 0, `dir` stays 1, no `dir_chg`.
- Heading RIGHT, pulses `btn_u`, `btn_l`, `btn_d` with no `step` (DEPTH = 2):
  - U and L accepted, `count` = 2.
  - D is legal against tail L but dropped, so `drop` pulses.
  - Two `step`s give `dir` = 0, then `dir` = 3.
- `btn_u` and `btn_r` pulsed in the same cycle: `count` stays 0, no `drop`.
- Queue [U, L] full, `btn_d` coincident with `step`: `dir` = 0, queue = [L, D], `count` = 2, no `drop`.
- Queue holds U, `run` = 0, `step` and `btn_l` pulsed: no change. Then `clear`: `dir` = 1, `count` = 0. Then async `reset` asserted mid-`step`: all outputs return to their reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game definitions: direction encoding, reset heading and
// the reversal test used by both the direction queue and the game core.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam logic [1:0] DIR_INIT  = DIR_RIGHT;

   // Opposite headings differ only in the upper bit of the encoding.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return (a ^ b) == 2'b10;
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// DEPTH-entry circular FIFO of 2-bit headings with push, pop and clear.
// Callers gate push/pop so the FIFO never overflows or underflows.
module dir_fifo
   import snake_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input  logic          board_clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [1:0]    push_data,
   output logic [1:0]    head,
   output logic [1:0]    tail,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] prev_ptr(input logic [PW-1:0] p);
      return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
   endfunction

   assign head  = mem_q[rd_ptr_q];
   assign tail  = mem_q[prev_ptr(wr_ptr_q)];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DIR_INIT;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/snake_dir_queue.sv
// Button-to-heading front end: decodes single presses, rejects reversals and
// duplicates, queues legal turns and releases one per game step.
module snake_dir_queue
   import snake_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input  logic          board_clk,
   input  logic          reset,
   input  logic          btn_u,
   input  logic          btn_r,
   input  logic          btn_d,
   input  logic          btn_l,
   input  logic          step,
   input  logic          run,
   input  logic          clear,
   output logic [1:0]    dir,
   output logic          dir_chg,
   output logic [CW-1:0] count,
   output logic          drop
);

   logic [1:0] dir_q, dir_d;
   logic       dir_chg_q, dir_chg_d;
   logic       drop_q, drop_d;

   logic       cand_valid;
   logic [1:0] cand;
   logic [1:0] ref_dir;
   logic       legal;
   logic       push_req;
   logic       fifo_push;
   logic       fifo_pop;
   logic [1:0] fifo_head;
   logic [1:0] fifo_tail;
   logic       fifo_full;
   logic       fifo_empty;

   // Only a single pressed button yields a candidate; chords are ignored.
   always_comb begin
      cand_valid = 1'b1;
      cand       = DIR_INIT;
      case ({btn_u, btn_r, btn_d, btn_l})
         4'b1000: cand = DIR_UP;
         4'b0100: cand = DIR_RIGHT;
         4'b0010: cand = DIR_DOWN;
         4'b0001: cand = DIR_LEFT;
         default: cand_valid = 1'b0;
      endcase
   end

   // Turns are judged against the last queued heading, not the current one.
   assign ref_dir   = fifo_empty ? dir_q : fifo_tail;
   assign legal     = cand_valid && (cand != ref_dir) && !is_reverse(cand, ref_dir);
   assign fifo_pop  = run && step && !fifo_empty;
   assign push_req  = run && legal;
   assign fifo_push = push_req && (!fifo_full || fifo_pop);

   always_comb begin
      dir_d     = dir_q;
      dir_chg_d = 1'b0;
      drop_d    = 1'b0;
      if (clear) begin
         dir_d = DIR_INIT;
      end else begin
         if (fifo_pop) begin
            dir_d     = fifo_head;
            dir_chg_d = 1'b1;
         end
         drop_d = push_req && fifo_full && !fifo_pop;
      end
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         dir_q     <= DIR_INIT;
         dir_chg_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         dir_chg_q <= dir_chg_d;
         drop_q    <= drop_d;
      end
   end

   dir_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .board_clk (board_clk),
      .reset     (reset),
      .clear     (clear),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .push_data (cand),
      .head      (fifo_head),
      .tail      (fifo_tail),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign dir     = dir_q;
   assign dir_chg = dir_chg_q;
   assign drop    = drop_q;

endmodule
